// File: rtl/cordic_ctrl.sv
// Custom-instruction sequencer for the CORDIC datapath: operand latch, special-operand bypass,
// core launch/wait and result return. Optional WAIT abort is enabled by defining CTRL_TIMEOUT_EN.
module cordic_ctrl #(
  parameter logic [31:0] SPECIAL_ZERO_RES = 32'h3f800000,
  parameter logic [31:0] SPECIAL_POS_RES  = 32'h3f0a5140,
  parameter logic [31:0] SPECIAL_NEG_RES  = 32'h3f0a5140,
  parameter int          TIMEOUT_CYCLES   = 64,
  parameter logic [31:0] TIMEOUT_RES      = 32'h7fc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        busy,
  output logic        err,
  output logic [31:0] unp_data,
  input  logic        unp_sign,
  input  logic [31:0] unp_fixed,
  input  logic        unp_special,
  output logic        core_start,
  output logic [31:0] core_angle,
  input  logic        core_done,
  input  logic [31:0] core_result
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] result_r, result_s;
  logic [31:0] unp_data_r, unp_data_s;
  logic [31:0] core_angle_r, core_angle_s;
  logic        timeout_s;

`ifdef CTRL_TIMEOUT_EN
  localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx_s;
  logic          err_r;

  // Timeout detection; a core_done in the same cycle takes priority
  always_comb begin
    cnt_nx_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    timeout_s = (state_r == ST_WAIT) && !core_done && (cnt_nx_s == TO_LIM);
  end

  // WAIT cycle counter, cleared while launching
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clk_en) begin
      if (state_r == ST_LAUNCH) begin
        cnt_r <= {CW{1'b0}};
      end else if ((state_r == ST_WAIT) && !core_done) begin
        cnt_r <= cnt_nx_s;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Error flag: set by a timeout, cleared when a new request is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (clk_en) begin
      if ((state_r == ST_IDLE) && start) begin
        err_r <= 1'b0;
      end else if (timeout_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign err = err_r;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state and registered-output update logic
  always_comb begin
    state_s      = state_r;
    result_s     = result_r;
    unp_data_s   = unp_data_r;
    core_angle_s = core_angle_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          unp_data_s = dataa;
          state_s    = ST_UNPACK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_UNPACK: begin
        if (unp_special) begin
          // Zero of either sign is told apart from +/-1 by the latched magnitude
          if (unp_data_r[30:0] == 31'd0) begin
            result_s = SPECIAL_ZERO_RES;
          end else if (unp_sign) begin
            result_s = SPECIAL_NEG_RES;
          end else begin
            result_s = SPECIAL_POS_RES;
          end
          state_s = ST_DONE;
        end else begin
          core_angle_s = unp_fixed;
          state_s      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          result_s = core_result;
          state_s  = ST_DONE;
        end else if (timeout_s) begin
          result_s = TIMEOUT_RES;
          state_s  = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, frozen while clk_en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      result_r     <= 32'h0000_0000;
      unp_data_r   <= 32'h0000_0000;
      core_angle_r <= 32'h0000_0000;
    end else if (clk_en) begin
      state_r      <= state_s;
      result_r     <= result_s;
      unp_data_r   <= unp_data_s;
      core_angle_r <= core_angle_s;
    end
  end

  assign done       = (state_r == ST_DONE);
  assign busy       = (state_r != ST_IDLE);
  assign core_start = (state_r == ST_LAUNCH);
  assign result     = result_r;
  assign unp_data   = unp_data_r;
  assign core_angle = core_angle_r;

endmodule

// File: tb/tb_cordic_ctrl.sv
// Directed self-checking bench for cordic_ctrl; timeout scenarios run only when CTRL_TIMEOUT_EN is defined.
module tb_cordic_ctrl;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;
  logic        busy;
  logic        err;
  logic [31:0] unp_data;
  logic        unp_sign;
  logic [31:0] unp_fixed;
  logic        unp_special;
  logic        core_start;
  logic [31:0] core_angle;
  logic        core_done;
  logic [31:0] core_result;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cs_cnt  = 0;

  cordic_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .start       (start),
    .dataa       (dataa),
    .done        (done),
    .result      (result),
    .busy        (busy),
    .err         (err),
    .unp_data    (unp_data),
    .unp_sign    (unp_sign),
    .unp_fixed   (unp_fixed),
    .unp_special (unp_special),
    .core_start  (core_start),
    .core_angle  (core_angle),
    .core_done   (core_done),
    .core_result (core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count enabled cycles in which a core launch is requested
  always @(posedge clk) begin
    if (clk_en && core_start && !reset) cs_cnt <= cs_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vec_cnt++; if (done !== 1'b0) begin $display("FAIL rst_done: got %b want %b", done, 1'b0); err_cnt++; end
    vec_cnt++; if (result !== 32'h0) begin $display("FAIL rst_result: got %h want %h", result, 32'h0); err_cnt++; end
    vec_cnt++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want %b", busy, 1'b0); err_cnt++; end
    vec_cnt++; if (err !== 1'b0) begin $display("FAIL rst_err: got %b want %b", err, 1'b0); err_cnt++; end
    vec_cnt++; if (core_start !== 1'b0) begin $display("FAIL rst_core_start: got %b want %b", core_start, 1'b0); err_cnt++; end
    vec_cnt++; if (unp_data !== 32'h0) begin $display("FAIL rst_unp_data: got %h want %h", unp_data, 32'h0); err_cnt++; end
    vec_cnt++; if (core_angle !== 32'h0) begin $display("FAIL rst_core_angle: got %h want %h", core_angle, 32'h0); err_cnt++; end
    reset = 1'b0;
    tick();
    vec_cnt++; if (busy !== 1'b0) begin $display("FAIL post_rst_busy: got %b want %b", busy, 1'b0); err_cnt++; end
  endtask

  // Special-operand path: start, check latency, pulse width, busy span and result
  task automatic test_special(input logic [31:0] d, input logic sgn, input logic [31:0] exp_res);
    int busy_n;
    int done_n;
    int cs0;
    cs0         = cs_cnt;
    dataa       = d;
    unp_special = 1'b1;
    unp_sign    = sgn;
    start       = 1'b1;
    tick();
    start = 1'b0;
    vec_cnt++; if (unp_data !== d) begin $display("FAIL sp_unp_data: got %h want %h", unp_data, d); err_cnt++; end
    vec_cnt++; if (done !== 1'b0) begin $display("FAIL sp_done_early: got %b want %b", done, 1'b0); err_cnt++; end
    busy_n = (busy === 1'b1) ? 1 : 0;
    done_n = 0;
    tick();
    vec_cnt++; if (done !== 1'b1) begin $display("FAIL sp_done_2nd: got %b want %b", done, 1'b1); err_cnt++; end
    vec_cnt++; if (result !== exp_res) begin $display("FAIL sp_result: got %h want %h", result, exp_res); err_cnt++; end
    for (int i = 0; i < 4; i++) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) done_n++;
      tick();
    end
    vec_cnt++; if (busy_n !== 2) begin $display("FAIL sp_busy_cycles: got %0d want %0d", busy_n, 2); err_cnt++; end
    vec_cnt++; if (done_n !== 1) begin $display("FAIL sp_done_width: got %0d want %0d", done_n, 1); err_cnt++; end
    vec_cnt++; if (result !== exp_res) begin $display("FAIL sp_result_held: got %h want %h", result, exp_res); err_cnt++; end
    vec_cnt++; if ((cs_cnt - cs0) !== 0) begin $display("FAIL sp_core_start: got %0d pulses want %0d", cs_cnt - cs0, 0); err_cnt++; end
    unp_special = 1'b0;
    unp_sign    = 1'b0;
  endtask

  task automatic test_specials();
    test_special(32'h3f800000, 1'b0, 32'h3f0a5140);
    test_special(32'h00000000, 1'b0, 32'h3f800000);
    test_special(32'h80000000, 1'b1, 32'h3f800000);
    test_special(32'hbf800000, 1'b1, 32'h3f0a5140);
  endtask

  task automatic test_core();
    int cs0;
    int early;
    cs0         = cs_cnt;
    dataa       = 32'h3f000000;
    unp_special = 1'b0;
    unp_fixed   = 32'h80000000;
    start       = 1'b1;
    tick();
    start = 1'b0;
    vec_cnt++; if (core_start !== 1'b0) begin $display("FAIL core_start_unpack: got %b want %b", core_start, 1'b0); err_cnt++; end
    tick();
    vec_cnt++; if (core_start !== 1'b1) begin $display("FAIL core_start_launch: got %b want %b", core_start, 1'b1); err_cnt++; end
    vec_cnt++; if (core_angle !== 32'h80000000) begin $display("FAIL core_angle: got %h want %h", core_angle, 32'h80000000); err_cnt++; end
    tick();
    vec_cnt++; if (core_start !== 1'b0) begin $display("FAIL core_start_wait: got %b want %b", core_start, 1'b0); err_cnt++; end
    early = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin start = 1'b1; dataa = 32'h40490fdb; end
      if (i == 6) start = 1'b0;
      if (done !== 1'b0) early++;
      tick();
    end
    vec_cnt++; if (early !== 0) begin $display("FAIL core_done_early: got %0d want %0d", early, 0); err_cnt++; end
    core_done   = 1'b1;
    core_result = 32'h3f60a940;
    tick();
    core_done   = 1'b0;
    core_result = 32'h0;
    vec_cnt++; if (done !== 1'b1) begin $display("FAIL core_done: got %b want %b", done, 1'b1); err_cnt++; end
    vec_cnt++; if (result !== 32'h3f60a940) begin $display("FAIL core_result: got %h want %h", result, 32'h3f60a940); err_cnt++; end
    vec_cnt++; if (err !== 1'b0) begin $display("FAIL core_err: got %b want %b", err, 1'b0); err_cnt++; end
    vec_cnt++; if (unp_data !== 32'h3f000000) begin $display("FAIL core_start_ignored: got %h want %h", unp_data, 32'h3f000000); err_cnt++; end
    tick();
    vec_cnt++; if (done !== 1'b0) begin $display("FAIL core_done_width: got %b want %b", done, 1'b0); err_cnt++; end
    vec_cnt++; if ((cs_cnt - cs0) !== 1) begin $display("FAIL core_start_count: got %0d want %0d", cs_cnt - cs0, 1); err_cnt++; end
  endtask

  task automatic test_launch_done();
    dataa       = 32'h3e800000;
    unp_fixed   = 32'h20000000;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tick();
    core_done   = 1'b1;
    core_result = 32'hdeadbeef;
    tick();
    core_done   = 1'b0;
    vec_cnt++; if (done !== 1'b0) begin $display("FAIL ld_ignored_done: got %b want %b", done, 1'b0); err_cnt++; end
    tick();
    tick();
    vec_cnt++; if (done !== 1'b0) begin $display("FAIL ld_still_wait: got %b want %b", done, 1'b0); err_cnt++; end
    core_done   = 1'b1;
    core_result = 32'h12345678;
    tick();
    core_done = 1'b0;
    vec_cnt++; if (result !== 32'h12345678) begin $display("FAIL ld_result: got %h want %h", result, 32'h12345678); err_cnt++; end
    tick();
  endtask

  task automatic test_clk_en();
    dataa     = 32'h3f400000;
    unp_fixed = 32'h11112222;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    clk_en      = 1'b0;
    core_done   = 1'b1;
    core_result = 32'h55555555;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec_cnt++; if ((busy !== 1'b1) || (done !== 1'b0)) begin $display("FAIL ce_freeze_wait: got busy=%b done=%b want busy=1 done=0", busy, done); err_cnt++; end
    end
    core_done = 1'b0;
    clk_en    = 1'b1;
    tick();
    vec_cnt++; if (done !== 1'b0) begin $display("FAIL ce_resume: got %b want %b", done, 1'b0); err_cnt++; end
    core_done   = 1'b1;
    core_result = 32'h0badf00d;
    tick();
    core_done = 1'b0;
    vec_cnt++; if (done !== 1'b1) begin $display("FAIL ce_done: got %b want %b", done, 1'b1); err_cnt++; end
    vec_cnt++; if (result !== 32'h0badf00d) begin $display("FAIL ce_result: got %h want %h", result, 32'h0badf00d); err_cnt++; end
    clk_en = 1'b0;
    tick();
    tick();
    vec_cnt++; if (done !== 1'b1) begin $display("FAIL ce_done_frozen: got %b want %b", done, 1'b1); err_cnt++; end
    clk_en = 1'b1;
    tick();
    vec_cnt++; if ((done !== 1'b0) || (busy !== 1'b0)) begin $display("FAIL ce_done_end: got done=%b busy=%b want 0 0", done, busy); err_cnt++; end
  endtask

  task automatic test_reset_mid();
    dataa     = 32'h3e000000;
    unp_fixed = 32'h0a0a0a0a;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    vec_cnt++; if ((busy !== 1'b0) || (done !== 1'b0) || (err !== 1'b0) || (core_start !== 1'b0)) begin $display("FAIL rm_async_ctl: got busy=%b done=%b err=%b cs=%b want 0", busy, done, err, core_start); err_cnt++; end
    vec_cnt++; if ((result !== 32'h0) || (unp_data !== 32'h0) || (core_angle !== 32'h0)) begin $display("FAIL rm_async_data: got %h %h %h want 0", result, unp_data, core_angle); err_cnt++; end
    tick();
    reset       = 1'b0;
    core_done   = 1'b1;
    core_result = 32'hcafecafe;
    tick();
    core_done = 1'b0;
    vec_cnt++; if ((done !== 1'b0) || (busy !== 1'b0) || (result !== 32'h0)) begin $display("FAIL rm_late_core_done: got done=%b busy=%b result=%h want 0 0 0", done, busy, result); err_cnt++; end
    tick();
    vec_cnt++; if (done !== 1'b0) begin $display("FAIL rm_no_done: got %b want %b", done, 1'b0); err_cnt++; end
  endtask

  task automatic test_back_to_back();
    dataa       = 32'h00000000;
    unp_special = 1'b1;
    unp_sign    = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vec_cnt++; if (done !== 1'b1) begin $display("FAIL b2b_first_done: got %b want %b", done, 1'b1); err_cnt++; end
    dataa = 32'h3f800000;
    start = 1'b1;
    tick();
    vec_cnt++; if ((busy !== 1'b0) || (unp_data !== 32'h0)) begin $display("FAIL b2b_start_in_done: got busy=%b unp_data=%h want 0 0", busy, unp_data); err_cnt++; end
    tick();
    start = 1'b0;
    vec_cnt++; if ((busy !== 1'b1) || (unp_data !== 32'h3f800000)) begin $display("FAIL b2b_accept: got busy=%b unp_data=%h want 1 3f800000", busy, unp_data); err_cnt++; end
    tick();
    vec_cnt++; if ((done !== 1'b1) || (result !== 32'h3f0a5140)) begin $display("FAIL b2b_second: got done=%b result=%h want 1 3f0a5140", done, result); err_cnt++; end
    tick();
    unp_special = 1'b0;
  endtask

`ifdef CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    dataa       = 32'h3f100000;
    unp_special = 1'b0;
    unp_fixed   = 32'h12340000;
    start       = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while ((done !== 1'b1) && (n < 200)) begin
      tick();
      n++;
    end
    vec_cnt++; if (n !== 67) begin $display("FAIL to_latency: got %0d edges want %0d", n, 67); err_cnt++; end
    vec_cnt++; if (result !== 32'h7fc00000) begin $display("FAIL to_result: got %h want %h", result, 32'h7fc00000); err_cnt++; end
    vec_cnt++; if (err !== 1'b1) begin $display("FAIL to_err: got %b want %b", err, 1'b1); err_cnt++; end
    tick();
    vec_cnt++; if (err !== 1'b1) begin $display("FAIL to_err_held: got %b want %b", err, 1'b1); err_cnt++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_cnt++; if (err !== 1'b0) begin $display("FAIL to_err_clear: got %b want %b", err, 1'b0); err_cnt++; end
    // Same operation again, with core_done landing on the limit cycle
    for (int i = 0; i < 65; i++) tick();
    core_done   = 1'b1;
    core_result = 32'h3e4ccccd;
    tick();
    core_done = 1'b0;
    vec_cnt++; if ((done !== 1'b1) || (result !== 32'h3e4ccccd) || (err !== 1'b0)) begin $display("FAIL to_core_wins: got done=%b result=%h err=%b want 1 3e4ccccd 0", done, result, err); err_cnt++; end
    tick();
  endtask
`endif

  initial begin
    reset       = 1'b1;
    clk_en      = 1'b1;
    start       = 1'b0;
    dataa       = 32'h0;
    unp_sign    = 1'b0;
    unp_fixed   = 32'h0;
    unp_special = 1'b0;
    core_done   = 1'b0;
    core_result = 32'h0;
    test_reset();
    test_specials();
    test_core();
    test_launch_done();
    test_clk_en();
    test_reset_mid();
    test_back_to_back();
`ifdef CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cordic_ctrl.md
Name: cordic_ctrl

Overview:
- Multi-cycle custom-instruction sequencer for the CORDIC datapath.
- Latches an IEEE-754 single operand and feeds it to the float-to-fixed unpacker.
- Special operands (0, +1, -1) bypass the core and return constant results.
- All other operands launch the iterative CORDIC core and wait for its completion; the result goes back over a start/done handshake with clock-enable gating.

Parameters:
- SPECIAL_ZERO_RES, 32'h3f800000, float result returned for operand 0 (±0).
- SPECIAL_POS_RES, 32'h3f0a5140, float result returned for operand +1.0.
- SPECIAL_NEG_RES, 32'h3f0a5140, float result returned for operand -1.0.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort (only with CTRL_TIMEOUT_EN).
- TIMEOUT_RES, 32'h7fc00000, result returned on timeout (quiet NaN).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  when low, all registers hold, including the timeout counter.
- start  in  1  request; sampled only in IDLE with clk_en=1.
- dataa  in  32  IEEE-754 operand.
- done  out  1  one-cycle completion pulse.
- result  out  32  float result; valid while done=1, held afterwards.
- busy  out  1  high in every state except IDLE.
- err  out  1  high with done when the operation timed out; else 0.
- unp_data  out  32  latched operand to the unpacker.
- unp_sign  in  1  unpacker sign.
- unp_fixed  in  32  unpacker fixed-point magnitude.
- unp_special  in  1  unpacker special flag.
- core_start  out  1  core launch pulse.
- core_angle  out  32  fixed-point operand to the core.
- core_done  in  1  core completion pulse.
- core_result  in  32  core float result; valid with core_done.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; done=0, result=0, busy=0, err=0, core_start=0, unp_data=0, core_angle=0, timeout counter=0.
- Reset asserted mid-operation aborts it. No done is issued, and a later core_done is ignored in IDLE.
- Every transition below requires clk_en=1; with clk_en=0 the state and outputs freeze.
- FSM states: IDLE, UNPACK, LAUNCH, WAIT, DONE.
- IDLE -> UNPACK on start=1: unp_data<=dataa.
- start in any other state is ignored; there is no queueing.
- UNPACK decodes the special operands:
  - Special operands are 32'h00000000, 32'h80000000, 32'h3f800000 and 32'hbf800000.
  - On unp_special=1: result<=SPECIAL_ZERO_RES for zero, SPECIAL_POS_RES for +1 (unp_sign=0), SPECIAL_NEG_RES for -1 (unp_sign=1).
  - Then -> DONE.
- UNPACK, non-special: core_angle<=unp_fixed, -> LAUNCH.
- LAUNCH: core_start=1 for exactly this one cycle (Moore output), then -> WAIT, counter cleared.
- WAIT: on core_done=1, result<=core_result and -> DONE. Otherwise the counter increments.
- DONE: done=1 for exactly one enabled cycle, then -> IDLE. A start during DONE is ignored.
- Latency from the edge sampling start to the first cycle with done=1:
  - Special path: 2 edges.
  - Core path: 3 edges plus the core's own latency.
  - Back-to-back starts are accepted from the cycle after done.
- core_done arriving in LAUNCH is ignored; core_done is honoured only in WAIT.
- busy is combinational from state.
- err is cleared on every new start.

Optional Feature:
- Macro name: CTRL_TIMEOUT_EN.
- Defined: a WAIT counter of width $clog2(TIMEOUT_CYCLES+1) runs.
  - When it reaches TIMEOUT_CYCLES without core_done: result<=TIMEOUT_RES, err<=1, -> DONE.
  - If core_done and the limit occur in the same cycle, core_done wins.
- Not defined: no counter is present and err is tied to 0. WAIT waits indefinitely.

Test Plan:
- start with dataa=32'h3f800000, unp_special=1, unp_sign=0 -> done on 2nd cycle, result=32'h3f0a5140, core_start never asserted.
- dataa=32'h00000000, unp_special=1 -> result=32'h3f800000; done width exactly 1 cycle; busy=1 for 2 cycles.
- dataa=32'h3f000000, unp_fixed=32'h80000000; core model returns 32'h3f60a940 after 20 cycles -> core_angle=32'h80000000, one core_start pulse, done 1 cycle after core_done, result=32'h3f60a940, err=0.
- Toggle clk_en low 5 cycles during WAIT -> state and counter frozen; done still follows core_done by 1 enabled cycle.
- Assert reset in WAIT, then pulse core_done -> all outputs 0, state IDLE, no done.
- With CTRL_TIMEOUT_EN, core never responds -> done after 64 WAIT cycles, result=32'h7fc00000, err=1. Then a new start clears err.
